dds_sweep_ctrl: RTL and testbench

Frequency-sweep scheduler for the DDS phase-accumulator/sine-ROM path. On a start request it latches a sweep configuration and steps the 32-bit frequency tuning word from a start value by a fixed increment. Each word is held for a programmable dwell. The block drives the accumulator's increment input and a phase-clear strobe, so every sweep begins at phase 0 and a waveform sweep runs with no CPU involvement.

---
 rtl/dds_sweep_ctrl.sv | 134 +++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the DDS accumulator: steps a tuning word from a
// start value by a fixed increment, holding each word for a programmable dwell.
module dds_sweep_ctrl #(
   parameter int unsigned FW_W    = 32,
   parameter int unsigned DWELL_W = 24,
   parameter int unsigned NSTEP_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [FW_W-1:0]    cfg_start_word,
   input  logic [FW_W-1:0]    cfg_step_word,
   input  logic               cfg_dir,
   input  logic [NSTEP_W-1:0] cfg_num_steps,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_repeat,
   output logic [FW_W-1:0]    fword,
   output logic               fword_upd,
   output logic               acc_clr,
   output logic               busy,
   output logic               done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [FW_W-1:0]    start_word;
      logic [FW_W-1:0]    step_word;
      logic               dir;
      logic [NSTEP_W-1:0] num_steps;
      logic [DWELL_W-1:0] dwell;
      logic               rpt;
   } sweep_cfg_t;

   state_t             state_q, state_d;
   sweep_cfg_t         cfg_q, cfg_d;
   logic [NSTEP_W-1:0] step_q, step_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [FW_W-1:0]    fword_d;
   logic               fword_upd_d, acc_clr_d, busy_d, done_d;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cfg_q     <= '0;
         step_q    <= '0;
         dwell_q   <= '0;
         fword     <= '0;
         fword_upd <= 1'b0;
         acc_clr   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         step_q    <= step_d;
         dwell_q   <= dwell_d;
         fword     <= fword_d;
         fword_upd <= fword_upd_d;
         acc_clr   <= acc_clr_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      cfg_d       = cfg_q;
      step_d      = step_q;
      dwell_d     = dwell_q;
      fword_d     = fword;
      fword_upd_d = 1'b0;
      acc_clr_d   = 1'b0;
      busy_d      = busy;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start && !abort) begin
               cfg_d.start_word = cfg_start_word;
               cfg_d.step_word  = cfg_step_word;
               cfg_d.dir        = cfg_dir;
               cfg_d.num_steps  = cfg_num_steps;
               // a zero dwell behaves as a one-cycle dwell
               cfg_d.dwell      = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
               cfg_d.rpt        = cfg_repeat;
               fword_d          = cfg_start_word;
               fword_upd_d      = 1'b1;
               acc_clr_d        = 1'b1;
               step_d           = '0;
               dwell_d          = cfg_d.dwell;
               busy_d           = 1'b1;
               state_d          = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (dwell_q != DWELL_W'(1)) begin
               dwell_d = dwell_q - DWELL_W'(1);
            end else if (step_q != cfg_q.num_steps) begin
               fword_d     = cfg_q.dir ? (fword - cfg_q.step_word)
                                       : (fword + cfg_q.step_word);
               step_d      = step_q + NSTEP_W'(1);
               dwell_d     = cfg_q.dwell;
               fword_upd_d = 1'b1;
            end else if (cfg_q.rpt) begin
               fword_d     = cfg_q.start_word;
               step_d      = '0;
               dwell_d     = cfg_q.dwell;
               fword_upd_d = 1'b1;
               acc_clr_d   = 1'b1;
            end else begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomized bench for dds_sweep_ctrl: outputs follow from the sweep schedule
// (word index = elapsed cycles / dwell) computed arithmetically each cycle.
module tb_dds_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] cfg_start_word = '0;
   logic [31:0] cfg_step_word = '0;
   logic        cfg_dir = 1'b0;
   logic [15:0] cfg_num_steps = '0;
   logic [23:0] cfg_dwell = '0;
   logic        cfg_repeat = 1'b0;
   logic [31:0] fword;
   logic        fword_upd, acc_clr, busy, done;

   int n_chk = 0;
   int n_fail = 0;

   dds_sweep_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_start_word(cfg_start_word), .cfg_step_word(cfg_step_word),
      .cfg_dir(cfg_dir), .cfg_num_steps(cfg_num_steps), .cfg_dwell(cfg_dwell),
      .cfg_repeat(cfg_repeat), .fword(fword), .fword_upd(fword_upd),
      .acc_clr(acc_clr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: elapsed cycles since the accepted start determine everything
   logic        m_act = 1'b0;
   longint      m_c = 0;
   logic [31:0] m_st = '0, m_sw = '0;
   logic        m_dir = 1'b0, m_rep = 1'b0;
   longint      m_n = 0, m_d = 1;
   logic [31:0] e_fword = '0;
   logic        e_upd = 1'b0, e_clr = 1'b0, e_busy = 1'b0, e_done = 1'b0;

   task automatic eval_model();
      longint p, idx, k;
      p = (m_n + 1) * m_d;
      if (!m_rep && m_c == 1 + p) begin
         e_done = 1'b1;
         e_busy = 1'b0;
         m_act  = 1'b0;
      end else begin
         idx     = m_rep ? (m_c - 1) % p : m_c - 1;
         k       = idx / m_d;
         e_fword = m_dir ? m_st - 32'(k) * m_sw : m_st + 32'(k) * m_sw;
         e_upd   = (idx % m_d) == 0;
         e_clr   = (idx == 0);
         e_busy  = 1'b1;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act = 1'b0; e_fword = '0; e_upd = 1'b0; e_clr = 1'b0;
         e_busy = 1'b0; e_done = 1'b0;
      end else begin
         e_upd = 1'b0; e_clr = 1'b0; e_done = 1'b0;
         if (!m_act) begin
            e_busy = 1'b0;
            if (start && !abort) begin
               m_st = cfg_start_word; m_sw = cfg_step_word; m_dir = cfg_dir;
               m_n = longint'(cfg_num_steps);
               m_d = (cfg_dwell == 0) ? 1 : longint'(cfg_dwell);
               m_rep = cfg_repeat; m_c = 1; m_act = 1'b1;
               eval_model();
            end
         end else if (abort) begin
            m_act  = 1'b0;
            e_busy = 1'b0;
         end else begin
            m_c++;
            eval_model();
         end
      end
   end

   // Per-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      check("fword", fword, e_fword);
      check("fword_upd", 32'(fword_upd), 32'(e_upd));
      check("acc_clr", 32'(acc_clr), 32'(e_clr));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_cfg(input logic [31:0] st, input logic [31:0] sw, input logic dir,
                          input logic [15:0] n, input logic [23:0] d, input logic rep);
      cfg_start_word = st; cfg_step_word = sw; cfg_dir = dir;
      cfg_num_steps = n; cfg_dwell = d; cfg_repeat = rep;
   endtask

   initial begin
      int nu, nc, nd, d_at;
      logic [31:0] w1, w2;

      #1;
      check("rst_fword", fword, 0);
      check("rst_busy", 32'({fword_upd, acc_clr, busy, done}), 0);
      #11 rst_n = 1'b1;
      cyc();

      // Up sweep
      set_cfg(100, 10, 1'b0, 3, 4, 1'b0);
      start = 1'b1;
      nu = 0; nc = 0; d_at = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         start = 1'b0;
         if (fword_upd) nu++;
         if (acc_clr) nc++;
         if (done && d_at == 0) d_at = i;
         if (i == 5) check("up_word1", fword, 110);
      end
      check("up_upd_cnt", 32'(nu), 4);
      check("up_clr_cnt", 32'(nc), 1);
      check("up_done_at", 32'(d_at), 17);
      check("up_final", fword, 130);

      // Down sweep with wrap
      set_cfg(5, 10, 1'b1, 1, 1, 1'b0);
      start = 1'b1;
      cyc(); start = 1'b0; w1 = fword;
      cyc(); w2 = fword;
      cyc();
      check("down_w0", w1, 5);
      check("down_w1", w2, 32'd4294967291);
      check("down_done", 32'(done), 1);
      cyc();

      // Repeat mode
      set_cfg(0, 8590, 1'b0, 2, 2, 1'b1);
      start = 1'b1;
      nc = 0; nd = 0;
      for (int i = 1; i <= 18; i++) begin
         cyc();
         start = 1'b0;
         if (acc_clr) nc++;
         if (done) nd++;
         if (i == 5) check("rep_w2", fword, 17180);
         if (i == 9) check("rep_w1_again", fword, 8590);
      end
      check("rep_clr_cnt", 32'(nc), 3);
      check("rep_no_done", 32'(nd), 0);
      abort = 1'b1;
      cyc(); abort = 1'b0;
      check("rep_abort_busy", 32'(busy), 0);

      // Abort during word 2, then start+abort together
      set_cfg(1000, 1, 1'b0, 4, 3, 1'b0);
      start = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         start = 1'b0;
      end
      abort = 1'b1;
      cyc(); abort = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_hold", fword, 1002);
      check("abort_no_done", 32'(done), 0);
      start = 1'b1; abort = 1'b1;
      cyc(); start = 1'b0; abort = 1'b0;
      check("start_abort_busy", 32'(busy), 0);
      check("start_abort_upd", 32'(fword_upd), 0);

      // D=0, N=0: one word for one cycle
      set_cfg(77, 3, 1'b0, 0, 0, 1'b0);
      start = 1'b1;
      cyc(); start = 1'b0;
      check("n0_word", fword, 77);
      cyc();
      check("n0_done", 32'(done), 1);
      cyc();

      // Config changes and start requests during RUN are ignored
      set_cfg(77, 3, 1'b0, 1, 0, 1'b0);
      start = 1'b1;
      cyc();
      set_cfg(9999, 500, 1'b1, 7, 9, 1'b1);
      cyc();
      check("shadow_w1", fword, 80);
      start = 1'b0;
      cyc();
      check("shadow_done", 32'(done), 1);
      cyc();
      check("no_queue_busy", 32'(busy), 0);

      // Asynchronous reset mid-sweep
      set_cfg(500, 7, 1'b0, 3, 4, 1'b0);
      start = 1'b1;
      cyc(); start = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      #1 rst_n = 1'b0;
      #1;
      check("arst_fword", fword, 0);
      check("arst_flags", 32'({fword_upd, acc_clr, busy, done}), 0);
      #2 rst_n = 1'b1;
      cyc();
      set_cfg(200, 1, 1'b0, 1, 2, 1'b0);
      start = 1'b1;
      cyc(); start = 1'b0;
      check("post_rst_w0", fword, 200);
      check("post_rst_clr", 32'(acc_clr), 1);
      for (int i = 0; i < 6; i++) cyc();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         cyc();
         start = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 1) == 0)
            set_cfg($urandom, $urandom, 1'($urandom), 16'($urandom_range(0, 5)),
                    24'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0));
      end
      start = 1'b0; abort = 1'b1;
      cyc(); abort = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
